// File: rtl/action_tbl_pkg.sv
// Shared types and helpers for the multi-channel action table.
// Optional per-byte parity storage is enabled with `define ACTION_PARITY_EN.
package action_tbl_pkg;

   localparam int unsigned DefEntries = 16;
   localparam int unsigned DefActionW = 64;
   localparam int unsigned DefNumCh   = 2;

   // Helpers work on a wide container; callers extend/truncate to their own width
   localparam int unsigned MaxW  = 512;
   localparam int unsigned MaxBe = MaxW / 8;

   typedef logic [MaxW-1:0]  word_t;
   typedef logic [MaxBe-1:0] be_t;

   typedef enum logic [0:0] {INIT, RUN} tbl_state_e;

   // Byte-wise merge: enabled bytes from new_w, the rest from old_w
   function automatic word_t merge_be(word_t old_w, word_t new_w, be_t be);
      word_t res;
      res = old_w;
      for (int i = 0; i < MaxBe; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   // Even parity bit per byte (XOR of the byte's bits)
   function automatic be_t byte_par(word_t w);
      be_t p;
      for (int i = 0; i < MaxBe; i++) begin
         p[i] = ^w[8*i +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/action_rd_chan.sv
// One read channel of the action table: request/response handshake, output
// register and write-first bypass for same-cycle write collisions.
// With `define ACTION_PARITY_EN the channel also reports a registered parity error.
module action_rd_chan #(
   parameter int unsigned AW       = 4,
   parameter int unsigned ACTION_W = 64,
   parameter int unsigned BE_W     = ACTION_W / 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [AW-1:0]       req_addr,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [ACTION_W-1:0] resp_data,
   input  logic [ACTION_W-1:0] rd_data,
   input  logic                wr_fire,
   input  logic [AW-1:0]       wr_addr,
   input  logic [ACTION_W-1:0] wr_data,
   input  logic [BE_W-1:0]     wr_be
`ifdef ACTION_PARITY_EN
   ,
   input  logic [BE_W-1:0]     rd_par,
   input  logic [BE_W-1:0]     wr_par,
   output logic                resp_perr
`endif
);
   import action_tbl_pkg::*;

   logic                fire;
   logic                byp_hit;
   logic [ACTION_W-1:0] rd_word;
   logic                resp_valid_q;
   logic [ACTION_W-1:0] resp_data_q;

   // Accept when the output register is empty or drains this cycle; bypass a colliding write
   always_comb begin
      req_ready = run && (!resp_valid_q || resp_ready);
      fire      = req_valid && req_ready;
      byp_hit   = wr_fire && (wr_addr == req_addr);
      rd_word   = byp_hit ? ACTION_W'(merge_be(word_t'(rd_data), word_t'(wr_data), be_t'(wr_be)))
                          : rd_data;
   end

   // Response register: load on fire, clear valid on drain, data holds its last value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
      end else if (fire) begin
         resp_valid_q <= 1'b1;
         resp_data_q  <= rd_word;
      end else if (resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;

`ifdef ACTION_PARITY_EN
   logic [BE_W-1:0] rd_par_m;
   logic            perr_d;
   logic            perr_q;

   // Check the (possibly bypassed) word against its merged stored parity
   always_comb begin
      rd_par_m = byp_hit ? ((rd_par & ~wr_be) | (wr_par & wr_be)) : rd_par;
      perr_d   = |(BE_W'(byte_par(word_t'(rd_word))) ^ rd_par_m);
   end

   // Parity flag travels with the response data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perr_q <= 1'b0;
      else if (fire) perr_q <= perr_d;
   end

   assign resp_perr = perr_q;
`endif

endmodule

// File: rtl/action_table_mc.sv
// Multi-channel action table: NUM_CH independent read channels, one byte-enabled
// write port and a zeroing sweep after reset or on clr_req.
// `define ACTION_PARITY_EN adds per-byte parity storage, resp_perr and inj_perr.
module action_table_mc #(
   parameter int unsigned  ENTRIES  = action_tbl_pkg::DefEntries,
   parameter int unsigned  ACTION_W = action_tbl_pkg::DefActionW,
   parameter int unsigned  NUM_CH   = action_tbl_pkg::DefNumCh,
   localparam int unsigned AW       = $clog2(ENTRIES),
   localparam int unsigned BE_W     = ACTION_W / 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          req_valid,
   output logic [NUM_CH-1:0]          req_ready,
   input  logic [NUM_CH*AW-1:0]       req_addr,
   output logic [NUM_CH-1:0]          resp_valid,
   input  logic [NUM_CH-1:0]          resp_ready,
   output logic [NUM_CH*ACTION_W-1:0] resp_data,
   input  logic                       wr_en,
   output logic                       wr_ready,
   input  logic [AW-1:0]              wr_addr,
   input  logic [ACTION_W-1:0]        wr_data,
   input  logic [BE_W-1:0]            wr_be,
   input  logic                       clr_req,
   output logic                       init_done
`ifdef ACTION_PARITY_EN
   ,
   output logic [NUM_CH-1:0]          resp_perr,
   input  logic                       inj_perr
`endif
);
   import action_tbl_pkg::*;

   tbl_state_e          state_q, state_d;
   logic [AW-1:0]       ptr_q;
   logic                run;
   logic                wr_fire;
   logic [ACTION_W-1:0] mem_q [ENTRIES];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= INIT;
      else        state_q <= state_d;
   end

   // FSM next state: sweep ends after the last entry; clear only honoured in RUN
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT:    if (ptr_q == AW'(ENTRIES - 1)) state_d = RUN;
         RUN:     if (clr_req) state_d = INIT;
         default: state_d = INIT;
      endcase
   end

   // FSM outputs: table is only usable in RUN
   always_comb begin
      run       = (state_q == RUN);
      wr_ready  = run;
      init_done = run;
      wr_fire   = wr_en && run;
   end

   // Sweep pointer; wraps to zero naturally at the end of a sweep
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                ptr_q <= '0;
      else if (state_q == INIT)  ptr_q <= ptr_q + AW'(1);
      else if (clr_req)          ptr_q <= '0;
   end

   // Storage: zero one entry per sweep cycle, otherwise apply byte-enabled writes
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         mem_q[ptr_q] <= '0;
      end else if (wr_fire) begin
         mem_q[wr_addr] <= ACTION_W'(merge_be(word_t'(mem_q[wr_addr]), word_t'(wr_data),
                                              be_t'(wr_be)));
      end
   end

`ifdef ACTION_PARITY_EN
   logic [BE_W-1:0] par_q [ENTRIES];
   logic [BE_W-1:0] wr_par;

   // Parity of the incoming bytes; inj_perr corrupts byte 0 for test
   always_comb begin
      wr_par = BE_W'(byte_par(word_t'(wr_data))) ^ {{(BE_W-1){1'b0}}, inj_perr};
   end

   // Parity storage follows the data array, merged per byte enable
   always_ff @(posedge clk) begin
      if (state_q == INIT) begin
         par_q[ptr_q] <= '0;
      end else if (wr_fire) begin
         par_q[wr_addr] <= (par_q[wr_addr] & ~wr_be) | (wr_par & wr_be);
      end
   end
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      action_rd_chan #(
         .AW       (AW),
         .ACTION_W (ACTION_W),
         .BE_W     (BE_W)
      ) u_chan (
         .clk        (clk),
         .rst_n      (rst_n),
         .run        (run),
         .req_valid  (req_valid[c]),
         .req_ready  (req_ready[c]),
         .req_addr   (req_addr[c*AW +: AW]),
         .resp_valid (resp_valid[c]),
         .resp_ready (resp_ready[c]),
         .resp_data  (resp_data[c*ACTION_W +: ACTION_W]),
         .rd_data    (mem_q[req_addr[c*AW +: AW]]),
         .wr_fire    (wr_fire),
         .wr_addr    (wr_addr),
         .wr_data    (wr_data),
         .wr_be      (wr_be)
`ifdef ACTION_PARITY_EN
         ,
         .rd_par     (par_q[req_addr[c*AW +: AW]]),
         .wr_par     (wr_par),
         .resp_perr  (resp_perr[c])
`endif
      );
   end

endmodule

// File: doc/action_table_mc.md
Name: action_table_mc

Overview:
Multi-channel action table, the successor to the single-port action memory in the DataPlane.
- NUM_CH independent read channels, each with a valid/ready request/response handshake so match stages can stall.
- One byte-enabled control-plane write port.
- Hardware init/clear sweep that zeroes every entry.
- Sits between the match/lookup stages and the action-execute stage.

Parameters:
ENTRIES, 16, number of action entries (power of 2, >=2)
ACTION_W, 64, action word width in bits (multiple of 8)
NUM_CH, 2, number of independent read channels (1..4)
AW, $clog2(ENTRIES), address width (derived, not overridden)
BE_W, ACTION_W/8, byte-enable width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_CH  per-channel lookup request valid
req_ready  out  NUM_CH  per-channel request accept
req_addr  in  NUM_CH*AW  per-channel entry index, channel c at [c*AW +: AW]
resp_valid  out  NUM_CH  per-channel response valid
resp_ready  in  NUM_CH  per-channel response accept
resp_data  out  NUM_CH*ACTION_W  per-channel action word
wr_en  in  1  write strobe, honoured only when wr_ready=1
wr_ready  out  1  write port available
wr_addr  in  AW  write index
wr_data  in  ACTION_W  write data
wr_be  in  BE_W  byte enables, bit i covers bits [8i+7:8i]
clr_req  in  1  one-cycle pulse starting a clear sweep
init_done  out  1  high when the table is usable

Behaviour:
Clock and reset:
- Single clock clk; rst_n is asynchronous, active-low.

Reset values:
- req_ready=0, resp_valid=0, resp_data=0, wr_ready=0, init_done=0, FSM=INIT, sweep pointer=0.

FSM:
- INIT: writes zero to entry[ptr] each cycle and increments ptr.
  - At ptr==ENTRIES-1, the write happens, then the FSM goes to RUN and init_done rises the next cycle.
  - A sweep takes exactly ENTRIES cycles.
- RUN: normal operation.
  - clr_req in RUN gives ptr=0, FSM=INIT and init_done=0 next cycle. Any resp already valid is held until accepted.
  - clr_req during INIT is ignored.
- In INIT: req_ready=0, wr_ready=0, and wr_en is ignored.

Read channel c (identical, independent):
- req_ready[c] = RUN && (!resp_valid[c] || resp_ready[c]).
- Fire = req_valid[c] && req_ready[c]. On fire, resp_data[c] = mem[addr] on the next edge and resp_valid[c]=1, giving 1-cycle latency.
- Full throughput: back-to-back fires are allowed when resp_ready[c]=1.
- resp_valid[c] && !resp_ready[c] holds resp_data[c] stable.
- Response without a new fire clears resp_valid[c]; resp_data keeps its last value.
- Multiple channels reading the same address in the same cycle all return identical data.

Write:
- On wr_en && wr_ready, each byte with wr_be[i]=1 is updated and other bytes are retained.
- wr_be=0 leaves the entry unchanged.

Read/write collision:
- A read fire and a write to the same address in the same cycle return the merged new value (write-first). Enabled bytes come from wr_data; the others come from the old entry.

Reset mid-operation:
- rst_n low at any time forces the reset values immediately.
- A new INIT sweep begins after deassertion.

Optional Feature:
ACTION_PARITY_EN
- Defined:
  - Each entry stores one even-parity bit per byte, computed on write and merged per wr_be; the sweep writes parity 0.
  - Extra output resp_perr (NUM_CH bits, reset 0) is valid alongside resp_valid[c] and is set if any byte's parity mismatches.
  - Extra input inj_perr (1 bit) inverts the stored parity of the byte-0 bit on the current write, for test.
- Undefined: no parity storage; resp_perr and inj_perr are absent.

Decomposition:
- Package action_tbl_pkg: localparam defaults (ENTRIES, ACTION_W, NUM_CH), FSM state enum {INIT, RUN}, byte-merge function merge_be(old,new,be), parity function.
- Sub-module action_rd_chan: one per channel via generate. It holds the handshake, output register and collision-bypass mux; the storage array and FSM stay in the top.

Test Plan:
1. Reset release -> init_done=0 for exactly 16 cycles, then 1; reading all 16 entries returns 64'h0.
2. Write addr 5 = 64'hDEAD_BEEF_0123_4567 with be=8'hFF, then be=8'h0F with data 64'h0 -> ch0 read of addr 5 returns 64'hDEAD_BEEF_0000_0000.
3. Same cycle: write addr 3 = 64'hAAAA..AA (be=8'hFF) and ch1 reads addr 3 -> ch1 resp_data=64'hAAAA..AA one cycle later.
4. ch0 resp_ready=0 for 4 cycles with req_valid held -> req_ready[0]=0 and resp_data stable; ch1 continues reading addrs 0..7 back-to-back at one per cycle.
5. clr_req in RUN with entries nonzero -> req_ready/wr_ready drop next cycle for 16 cycles and a wr_en there is dropped; all reads afterwards return 0.
6. ACTION_PARITY_EN: write with inj_perr=1 to addr 9, then read -> resp_perr[0]=1; rewrite addr 9 without inj_perr -> resp_perr[0]=0.
